// File: rtl/defines_pkg.sv
// defines_pkg: shared constants and FSM state encoding for the link time arbiter
package defines_pkg;
    localparam logic [2:0] MON_MODE_ALL_OFF    = 3'd0;
    localparam logic [2:0] MON_MODE_STATS_ONLY = 3'd1;
    localparam logic [2:0] MON_MODE_EMERGENCY  = 3'd2;
    localparam logic [2:0] MON_MODE_REDUCED    = 3'd3;
    localparam logic [2:0] MON_MODE_NORMAL     = 3'd4;
    localparam int TA_WIDTH_OF_PKT_CNTR = 5;
    localparam int TA_SIZEOF_CF_DATA    = 4;
    localparam int TA_SIZEOF_INTSTATS   = 16;
    localparam int LF_EXTR_DATA_MAX     = 2003;
    localparam int LF_INT_STATS_MAX     = 2015;
    localparam int CF_USEDW_WIDTH       = 10;
    localparam int ARB_FIFO_USEDW_W     = 9;
    localparam int LF_BIT_WIDTH_WR      = 11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CH0   = 2'd1,
        ST_CH1   = 2'd2,
        ST_STATS = 2'd3
    } lta_state_t;
endpackage

// File: rtl/lta_grant_sel.sv
// lta_grant_sel: combinational grant decision taken in IDLE; stats first, then round-robin channels
module lta_grant_sel
    import defines_pkg::*;
#(
    parameter int CF_USEDW_W = CF_USEDW_WIDTH,
    parameter int IS_USEDW_W = ARB_FIFO_USEDW_W,
    parameter int LF_USEDW_W = LF_BIT_WIDTH_WR,
    parameter int EXTR_MAX   = LF_EXTR_DATA_MAX,
    parameter int STATS_MAX  = LF_INT_STATS_MAX
) (
    input  logic [2:0]            mode,
    input  logic [CF_USEDW_W-1:0] ch0_usedw,
    input  logic [CF_USEDW_W-1:0] ch1_usedw,
    input  logic [IS_USEDW_W-1:0] is_usedw,
    input  logic [LF_USEDW_W-1:0] lf_usedw,
    input  logic                  ptr,
    output logic                  gnt,
    output lta_state_t            src
);
    logic stats_ok, ext_ok, ch0_ok, ch1_ok;
    // undefined mode encodings fall outside both sets and therefore behave as ALL_OFF
    assign stats_ok = mode inside {MON_MODE_STATS_ONLY, MON_MODE_EMERGENCY, MON_MODE_REDUCED, MON_MODE_NORMAL}
                      && is_usedw >= IS_USEDW_W'(TA_SIZEOF_INTSTATS) && lf_usedw < LF_USEDW_W'(STATS_MAX);
    assign ext_ok = mode inside {MON_MODE_EMERGENCY, MON_MODE_REDUCED, MON_MODE_NORMAL}
                    && lf_usedw < LF_USEDW_W'(EXTR_MAX);
    assign ch0_ok = ext_ok && ch0_usedw >= CF_USEDW_W'(TA_SIZEOF_CF_DATA);
    assign ch1_ok = ext_ok && ch1_usedw >= CF_USEDW_W'(TA_SIZEOF_CF_DATA);
    assign src = stats_ok         ? ST_STATS :
                 ch0_ok && ch1_ok ? (ptr ? ST_CH0 : ST_CH1) :
                 ch0_ok           ? ST_CH0 :
                 ch1_ok           ? ST_CH1 : ST_IDLE;
    assign gnt = src != ST_IDLE;
endmodule

// File: rtl/link_time_arbiter.sv
// link_time_arbiter: whole-packet time multiplexer of ch0/ch1/stats FIFOs onto the link FIFO write port
// LINK_TIME_ARBITER_PKT_CNT_EN adds per-source completed-packet counters with a synchronous clear
module link_time_arbiter
    import defines_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int CF_USEDW_W = CF_USEDW_WIDTH,
    parameter int IS_USEDW_W = ARB_FIFO_USEDW_W,
    parameter int LF_USEDW_W = LF_BIT_WIDTH_WR,
    parameter int EXTR_MAX   = LF_EXTR_DATA_MAX,
    parameter int STATS_MAX  = LF_INT_STATS_MAX
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [2:0]            iMON_MODE,
    input  logic [DATA_W-1:0]     iCH0_DATA,
    input  logic [CF_USEDW_W-1:0] iCH0_USEDW,
    input  logic                  iCH0_EMPTY,
    output logic                  oCH0_RDREQ,
    input  logic [DATA_W-1:0]     iCH1_DATA,
    input  logic [CF_USEDW_W-1:0] iCH1_USEDW,
    input  logic                  iCH1_EMPTY,
    output logic                  oCH1_RDREQ,
    input  logic [DATA_W-1:0]     iIS_DATA,
    input  logic [IS_USEDW_W-1:0] iIS_USEDW,
    input  logic                  iIS_EMPTY,
    output logic                  oIS_RDREQ,
    input  logic [LF_USEDW_W-1:0] iLF_WRUSEDW,
    output logic [DATA_W-1:0]     oLF_DATA,
    output logic                  oLF_WRREQ,
    output logic [1:0]            oSTATE
`ifdef LINK_TIME_ARBITER_PKT_CNT_EN
    ,
    input  logic                  iCNT_CLR,
    output logic [31:0]           oCH0_PKT_CNT,
    output logic [31:0]           oCH1_PKT_CNT,
    output logic [31:0]           oIS_PKT_CNT
`endif
);
    localparam int CW = TA_WIDTH_OF_PKT_CNTR;
    lta_state_t state, src;
    logic ptr, gnt, rd, last;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] rd_data;

    lta_grant_sel #(
        .CF_USEDW_W(CF_USEDW_W), .IS_USEDW_W(IS_USEDW_W), .LF_USEDW_W(LF_USEDW_W),
        .EXTR_MAX(EXTR_MAX), .STATS_MAX(STATS_MAX)
    ) u_sel (
        .mode(iMON_MODE), .ch0_usedw(iCH0_USEDW), .ch1_usedw(iCH1_USEDW), .is_usedw(iIS_USEDW),
        .lf_usedw(iLF_WRUSEDW), .ptr(ptr), .gnt(gnt), .src(src)
    );

    // read acknowledges are combinational so the show-ahead word is consumed in the cycle it is seen
    assign oCH0_RDREQ = state == ST_CH0 && !iCH0_EMPTY;
    assign oCH1_RDREQ = state == ST_CH1 && !iCH1_EMPTY;
    assign oIS_RDREQ  = state == ST_STATS && !iIS_EMPTY;
    assign rd = oCH0_RDREQ || oCH1_RDREQ || oIS_RDREQ;
    assign rd_data = state == ST_CH0 ? iCH0_DATA : state == ST_CH1 ? iCH1_DATA : iIS_DATA;
    assign last = cnt == (state == ST_STATS ? CW'(TA_SIZEOF_INTSTATS - 1) : CW'(TA_SIZEOF_CF_DATA - 1));
    assign oSTATE = state;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            cnt       <= '0;
            oLF_DATA  <= '0;
            oLF_WRREQ <= 1'b0;
        end else begin
            oLF_WRREQ <= rd;
            if (rd)
                oLF_DATA <= rd_data;
            if (state == ST_IDLE) begin
                if (gnt)
                    state <= src;
            end else if (rd) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    state <= ST_IDLE;
                    if (state != ST_STATS)
                        ptr <= state == ST_CH1;
                end
            end
        end
    end

`ifdef LINK_TIME_ARBITER_PKT_CNT_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST || iCNT_CLR) begin
            oCH0_PKT_CNT <= '0;
            oCH1_PKT_CNT <= '0;
            oIS_PKT_CNT  <= '0;
        end else if (rd && last) begin
            oCH0_PKT_CNT <= oCH0_PKT_CNT + {31'd0, state == ST_CH0};
            oCH1_PKT_CNT <= oCH1_PKT_CNT + {31'd0, state == ST_CH1};
            oIS_PKT_CNT  <= oIS_PKT_CNT + {31'd0, state == ST_STATS};
        end
    end
`endif
endmodule

// File: tb/tb_link_time_arbiter.sv
// tb_link_time_arbiter: randomized and directed checks against a packet-level arbitration model
module tb_link_time_arbiter;
    import defines_pkg::*;
    logic iCLK = 1'b0, iRST = 1'b1;
    logic [2:0] iMON_MODE = '0;
    logic [127:0] iCH0_DATA = '0, iCH1_DATA = '0, iIS_DATA = '0;
    logic [9:0] iCH0_USEDW = '0, iCH1_USEDW = '0;
    logic [8:0] iIS_USEDW = '0;
    logic iCH0_EMPTY = 1'b1, iCH1_EMPTY = 1'b1, iIS_EMPTY = 1'b1;
    logic [10:0] iLF_WRUSEDW = '0;
    logic oCH0_RDREQ, oCH1_RDREQ, oIS_RDREQ, oLF_WRREQ;
    logic [127:0] oLF_DATA;
    logic [1:0] oSTATE;
`ifdef LINK_TIME_ARBITER_PKT_CNT_EN
    logic iCNT_CLR = 1'b0;
    logic [31:0] oCH0_PKT_CNT, oCH1_PKT_CNT, oIS_PKT_CNT;
`endif

    link_time_arbiter dut (
        .iCLK(iCLK), .iRST(iRST), .iMON_MODE(iMON_MODE),
        .iCH0_DATA(iCH0_DATA), .iCH0_USEDW(iCH0_USEDW), .iCH0_EMPTY(iCH0_EMPTY), .oCH0_RDREQ(oCH0_RDREQ),
        .iCH1_DATA(iCH1_DATA), .iCH1_USEDW(iCH1_USEDW), .iCH1_EMPTY(iCH1_EMPTY), .oCH1_RDREQ(oCH1_RDREQ),
        .iIS_DATA(iIS_DATA), .iIS_USEDW(iIS_USEDW), .iIS_EMPTY(iIS_EMPTY), .oIS_RDREQ(oIS_RDREQ),
        .iLF_WRUSEDW(iLF_WRUSEDW), .oLF_DATA(oLF_DATA), .oLF_WRREQ(oLF_WRREQ), .oSTATE(oSTATE)
`ifdef LINK_TIME_ARBITER_PKT_CNT_EN
        , .iCNT_CLR(iCNT_CLR), .oCH0_PKT_CNT(oCH0_PKT_CNT), .oCH1_PKT_CNT(oCH1_PKT_CNT), .oIS_PKT_CNT(oIS_PKT_CNT)
`endif
    );

    always #5 iCLK = ~iCLK;

    int checks = 0, errors = 0;
    logic [127:0] q0[$], q1[$], qi[$], exp_q[$];
    int exp_cycles, cyc, last_wr, spct, ch1_pops, stall1_at = -1, f1;
    int pkts[3];
    bit m_ptr;

    task automatic check(input logic [127:0] obs, input logic [127:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n0, input int n1, input int ni);
        for (int i = 0; i < n0; i++) q0.push_back({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < n1; i++) q1.push_back({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < ni; i++) qi.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic update_inputs();
        logic s0, s1, si;
        s0 = spct != 0 && $urandom_range(99) < spct;
        s1 = spct != 0 && $urandom_range(99) < spct;
        si = spct != 0 && $urandom_range(99) < spct;
        if (ch1_pops == stall1_at) begin
            f1 = 3;
            stall1_at = -1;
        end
        s1 = s1 || f1 > 0;
        if (f1 > 0) f1--;
        iCH0_EMPTY = q0.size() == 0 || s0;
        iCH1_EMPTY = q1.size() == 0 || s1;
        iIS_EMPTY  = qi.size() == 0 || si;
        iCH0_DATA = q0.size() != 0 ? q0[0] : '0;
        iCH1_DATA = q1.size() != 0 ? q1[0] : '0;
        iIS_DATA  = qi.size() != 0 ? qi[0] : '0;
        iCH0_USEDW = 10'(q0.size());
        iCH1_USEDW = 10'(q1.size());
        iIS_USEDW  = 9'(qi.size());
    endtask

    // Packet-level model: replays the grant rules over the pending FIFO contents
    task automatic run_model();
        logic [127:0] a0[$], a1[$], ai[$];
        bit st_ok, ch_ok, e0, e1, go;
        int src, n;
        a0 = q0; a1 = q1; ai = qi;
        exp_q.delete();
        exp_cycles = 0;
        go = 1;
        ch_ok = iMON_MODE inside {MON_MODE_EMERGENCY, MON_MODE_REDUCED, MON_MODE_NORMAL} && iLF_WRUSEDW < 2003;
        while (go) begin
            st_ok = iMON_MODE inside {MON_MODE_STATS_ONLY, MON_MODE_EMERGENCY, MON_MODE_REDUCED, MON_MODE_NORMAL}
                    && ai.size() >= 16 && iLF_WRUSEDW < 2015;
            e0 = ch_ok && a0.size() >= 4;
            e1 = ch_ok && a1.size() >= 4;
            src = st_ok ? 2 : (e0 && e1) ? (m_ptr ? 0 : 1) : e0 ? 0 : e1 ? 1 : -1;
            if (src < 0) begin
                go = 0;
            end else begin
                n = src == 2 ? 16 : 4;
                for (int i = 0; i < n; i++)
                    exp_q.push_back(src == 0 ? a0.pop_front() : src == 1 ? a1.pop_front() : ai.pop_front());
                if (src < 2) m_ptr = src[0];
                pkts[src]++;
                exp_cycles += 1 + n;
            end
        end
    endtask

    task automatic tick();
        logic r0, r1, ri;
        @(negedge iCLK);
        r0 = oCH0_RDREQ; r1 = oCH1_RDREQ; ri = oIS_RDREQ;
        check({r0 && iCH0_EMPTY, r1 && iCH1_EMPTY, ri && iIS_EMPTY}, 0, "rdreq_while_empty");
        check($onehot0({r0, r1, ri}), 1, "rdreq_onehot");
        @(posedge iCLK);
        #1;
        cyc++;
        check(oLF_WRREQ, r0 || r1 || ri, "wrreq_follows_read");
        if (oLF_WRREQ) begin
            check(exp_q.size() != 0, 1, "unexpected_write");
            if (exp_q.size() != 0) check(oLF_DATA, exp_q.pop_front(), "write_data");
            last_wr = cyc;
        end
        if (r0) void'(q0.pop_front());
        if (r1) begin
            void'(q1.pop_front());
            ch1_pops++;
        end
        if (ri) void'(qi.pop_front());
        update_inputs();
    endtask

    task automatic run_trial(input int pct, input int extra);
        int budget;
        spct = pct;
        update_inputs();
        run_model();
        cyc = 0;
        last_wr = 0;
        budget = exp_cycles * 4 + 40;
        while (exp_q.size() != 0 && cyc < budget) tick();
        check(exp_q.size(), 0, "trial_words_outstanding");
        if (pct == 0) check(last_wr, exp_cycles + extra, "throughput");
        for (int i = 0; i < 3; i++) tick();
        check(oSTATE, ST_IDLE, "idle_after_trial");
`ifdef LINK_TIME_ARBITER_PKT_CNT_EN
        check({oCH0_PKT_CNT, oCH1_PKT_CNT, oIS_PKT_CNT}, {pkts[0], pkts[1], pkts[2]}, "pkt_counters");
`endif
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); qi.delete();
    endtask

    initial begin
        @(posedge iCLK);
        #1;
        check({oCH0_RDREQ, oCH1_RDREQ, oIS_RDREQ, oLF_WRREQ, oSTATE}, 0, "reset_ctrl");
        check(oLF_DATA, 0, "reset_data");
        iRST = 1'b0;
        // single ch0 packet: 1 decision cycle + 4 reads
        load(4, 0, 0);
        iMON_MODE = MON_MODE_NORMAL;
        run_trial(0, 0);
        // stats first, then channel alternation
        load(8, 8, 16);
        run_trial(0, 0);
        // link fill thresholds
        load(4, 0, 16);
        iLF_WRUSEDW = 11'd2003;
        run_trial(0, 0);
        check(q0.size(), 4, "ch0_blocked_at_extr_max");
        load(0, 0, 16);
        iLF_WRUSEDW = 11'd2015;
        run_trial(0, 0);
        check(qi.size(), 16, "stats_blocked_at_stats_max");
        iLF_WRUSEDW = 11'd0;
        clear_q();
        load(4, 0, 0);
        iMON_MODE = MON_MODE_STATS_ONLY;
        run_trial(0, 0);
        check(q0.size(), 4, "stats_only_no_ch_reads");
        clear_q();
        load(0, 0, 16);
        iMON_MODE = MON_MODE_ALL_OFF;
        run_trial(0, 0);
        check(qi.size(), 16, "all_off_no_reads");
        // ch1 source runs dry for 3 cycles after two words
        clear_q();
        load(0, 4, 0);
        iMON_MODE = MON_MODE_NORMAL;
        stall1_at = ch1_pops + 2;
        run_trial(0, 3);
        // reset while the third stats word is pending
        clear_q();
        load(0, 0, 32);
        spct = 0;
        update_inputs();
        run_model();
        cyc = 0;
        tick(); tick(); tick();
        check(oSTATE, ST_STATS, "stats_granted_before_reset");
        #2 iRST = 1'b1;
        #1;
        check({oCH0_RDREQ, oCH1_RDREQ, oIS_RDREQ, oLF_WRREQ, oSTATE}, 0, "async_reset_ctrl");
        check(oLF_DATA, 0, "async_reset_data");
        check(qi.size(), 30, "words_consumed_before_reset");
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        m_ptr = 0;
        pkts = '{0, 0, 0};
        exp_q.delete();
        run_trial(0, 0);
        check(qi.size(), 14, "fresh_packet_after_reset");
        // randomized trials with random source stalls
        for (int t = 0; t < 40; t++) begin
            load(q0.size() < 200 ? $urandom_range(9) : 0, q1.size() < 200 ? $urandom_range(9) : 0,
                 qi.size() < 200 ? $urandom_range(34) : 0);
            iMON_MODE = 3'($urandom_range(7));
            case ($urandom_range(6))
                0: iLF_WRUSEDW = 11'd0;
                1: iLF_WRUSEDW = 11'd2002;
                2: iLF_WRUSEDW = 11'd2003;
                3: iLF_WRUSEDW = 11'd2014;
                4: iLF_WRUSEDW = 11'd2015;
                5: iLF_WRUSEDW = 11'd2047;
                default: iLF_WRUSEDW = 11'($urandom_range(2047));
            endcase
            run_trial(t % 2 == 1 ? $urandom_range(40) : 0, 0);
        end
`ifdef LINK_TIME_ARBITER_PKT_CNT_EN
        iCNT_CLR = 1'b1;
        tick();
        iCNT_CLR = 1'b0;
        pkts = '{0, 0, 0};
        check({oCH0_PKT_CNT, oCH1_PKT_CNT, oIS_PKT_CNT}, 0, "pkt_counter_clear");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
